game_link_tx: RTL and testbench

Serial transmitter for the board-to-board game link. It frames READY and SCORE messages into 8N1 UART bytes and drives the TX line to the peer board. The peer's UART receiver turns these bytes into the `uart_start` and remote-score signals consumed by its game state machine. Requests come from the local game control logic in the `pclk` domain.

---
 rtl/game_link_pkg.sv | 33 +++
 rtl/game_link_tx_if.sv | 24 ++
 rtl/uart_tx_byte.sv | 141 ++++++++++++++
 rtl/game_link_tx.sv | 95 +++++++++
 tb/tb_game_link_tx.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/game_link_pkg.sv
// Shared constants and encodings for the board-to-board game link.
// GAME_LINK_TX_PARITY_EN adds the parity bit state to the byte serializer encoding.
package game_link_pkg;

    localparam logic [7:0] MSG_READY = 8'hA5;
    localparam logic [7:0] MSG_SCORE = 8'h5C;

    localparam logic [2:0] MSG_LEN_READY = 3'd1;
    localparam logic [2:0] MSG_LEN_SCORE = 3'd4;

    // Game state encoding, shared with the receiver side of the link.
    typedef enum logic [1:0] {
        GS_IDLE  = 2'd0,
        GS_WAIT  = 2'd1,
        GS_GAME  = 2'd2,
        GS_SCORE = 2'd3
    } game_state_e;

    typedef enum logic [2:0] {
        BYTE_IDLE   = 3'd0,
        BYTE_START  = 3'd1,
        BYTE_DATA   = 3'd2,
`ifdef GAME_LINK_TX_PARITY_EN
        BYTE_PARITY = 3'd3,
`endif
        BYTE_STOP   = 3'd4
    } byte_state_e;

    function automatic logic [7:0] score_checksum(input logic [15:0] s);
        return MSG_SCORE ^ s[15:8] ^ s[7:0];
    endfunction

endpackage

// File: rtl/game_link_tx_if.sv
// Request/serial-line bundle between game control and the link transmitter.
// Handshake: a request is taken on any pclk edge where busy is low; requests while busy is high are dropped.
interface game_link_tx_if;
    import game_link_pkg::*;

    logic        send_ready;
    logic        send_score;
    logic [15:0] score;
    logic        tx;
    logic        busy;
    logic        done;
    byte_state_e byte_state;

    modport master (
        output send_ready, send_score, score,
        input  tx, busy, done, byte_state
    );

    modport slave (
        input  send_ready, send_score, score,
        output tx, busy, done, byte_state
    );

endinterface

// File: rtl/uart_tx_byte.sv
// Byte serializer: start bit, 8 data bits LSB first, optional even parity, stop bit.
// With GAME_LINK_TX_PARITY_EN defined each frame carries an even-parity bit before the stop bit.
module uart_tx_byte
    import game_link_pkg::*;
#(
    parameter int CLKS_PER_BIT = 564
) (
    input  logic        pclk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  data,
    output logic        tx,
    output logic        byte_done,
    output byte_state_e state_dbg
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    byte_state_e      state_q, state_n;
    logic [CNT_W-1:0] cnt_q, cnt_n;
    logic [2:0]       bit_q, bit_n;
    logic [7:0]       shr_q, shr_n;
    logic             tx_q, tx_n;
    logic             bit_end;
`ifdef GAME_LINK_TX_PARITY_EN
    logic             par_q, par_n;
`endif

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BYTE_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shr_q   <= '0;
            tx_q    <= 1'b1;
`ifdef GAME_LINK_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            bit_q   <= bit_n;
            shr_q   <= shr_n;
            tx_q    <= tx_n;
`ifdef GAME_LINK_TX_PARITY_EN
            par_q   <= par_n;
`endif
        end
    end

    assign bit_end = (cnt_q == CNT_LAST);

    // tx_n is the line level for the next cycle, so the line always comes from tx_q.
    always_comb begin
        state_n   = state_q;
        cnt_n     = cnt_q;
        bit_n     = bit_q;
        shr_n     = shr_q;
        tx_n      = tx_q;
        byte_done = 1'b0;
`ifdef GAME_LINK_TX_PARITY_EN
        par_n     = par_q;
`endif
        if (state_q != BYTE_IDLE) begin
            cnt_n = bit_end ? '0 : cnt_q + 1'b1;
        end
        case (state_q)
            BYTE_IDLE: begin
                tx_n = 1'b1;
                if (start) begin
                    state_n = BYTE_START;
                    cnt_n   = '0;
                    shr_n   = data;
                    tx_n    = 1'b0;
`ifdef GAME_LINK_TX_PARITY_EN
                    par_n   = ^data;
`endif
                end
            end
            BYTE_START: begin
                if (bit_end) begin
                    state_n = BYTE_DATA;
                    bit_n   = '0;
                    tx_n    = shr_q[0];
                end
            end
            BYTE_DATA: begin
                if (bit_end) begin
                    if (bit_q == 3'd7) begin
`ifdef GAME_LINK_TX_PARITY_EN
                        state_n = BYTE_PARITY;
                        tx_n    = par_q;
`else
                        state_n = BYTE_STOP;
                        tx_n    = 1'b1;
`endif
                    end else begin
                        bit_n = bit_q + 3'd1;
                        shr_n = {1'b0, shr_q[7:1]};
                        tx_n  = shr_q[1];
                    end
                end
            end
`ifdef GAME_LINK_TX_PARITY_EN
            BYTE_PARITY: begin
                if (bit_end) begin
                    state_n = BYTE_STOP;
                    tx_n    = 1'b1;
                end
            end
`endif
            BYTE_STOP: begin
                if (bit_end) begin
                    byte_done = 1'b1;
                    // A start here chains the next frame with no idle cycle.
                    if (start) begin
                        state_n = BYTE_START;
                        shr_n   = data;
                        tx_n    = 1'b0;
`ifdef GAME_LINK_TX_PARITY_EN
                        par_n   = ^data;
`endif
                    end else begin
                        state_n = BYTE_IDLE;
                        tx_n    = 1'b1;
                    end
                end
            end
            default: begin
                state_n = BYTE_IDLE;
                cnt_n   = '0;
                tx_n    = 1'b1;
            end
        endcase
    end

    assign tx        = tx_q;
    assign state_dbg = state_q;

endmodule

// File: rtl/game_link_tx.sv
// Game link transmitter: request arbitration, score latch and message sequencing over uart_tx_byte.
// GAME_LINK_TX_PARITY_EN (passed through to uart_tx_byte) selects 8E1 framing.
module game_link_tx
    import game_link_pkg::*;
#(
    parameter int CLKS_PER_BIT = 564
) (
    input  logic          pclk,
    input  logic          rst_n,
    game_link_tx_if.slave link
);

    logic        busy_q;
    logic        done_q;
    logic [15:0] score_q;
    logic [2:0]  len_q;
    logic [1:0]  idx_q;

    logic        accept;
    logic        last_byte;
    logic        byte_start;
    logic [7:0]  byte_data;
    logic        byte_done;
    logic        tx_line;
    byte_state_e byte_state;

    function automatic logic [7:0] msg_byte(input logic [1:0] idx, input logic is_score,
                                            input logic [15:0] s);
        case (idx)
            2'd0:    return is_score ? MSG_SCORE : MSG_READY;
            2'd1:    return s[15:8];
            2'd2:    return s[7:0];
            default: return score_checksum(s);
        endcase
    endfunction

    assign accept    = !busy_q && (link.send_ready || link.send_score);
    assign last_byte = ({1'b0, idx_q} == (len_q - 3'd1));

    // The first byte is chosen from the live request; later bytes come from the latched score.
    always_comb begin
        byte_start = 1'b0;
        byte_data  = 8'h00;
        if (accept) begin
            byte_start = 1'b1;
            byte_data  = msg_byte(2'd0, link.send_score, link.score);
        end else if (byte_done && !last_byte) begin
            byte_start = 1'b1;
            byte_data  = msg_byte(idx_q + 2'd1, 1'b1, score_q);
        end
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            score_q <= '0;
            len_q   <= '0;
            idx_q   <= '0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                busy_q  <= 1'b1;
                score_q <= link.score;
                len_q   <= link.send_score ? MSG_LEN_SCORE : MSG_LEN_READY;
                idx_q   <= '0;
            end else if (byte_done) begin
                if (last_byte) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end else begin
                    idx_q <= idx_q + 2'd1;
                end
            end
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_byte (
        .pclk      (pclk),
        .rst_n     (rst_n),
        .start     (byte_start),
        .data      (byte_data),
        .tx        (tx_line),
        .byte_done (byte_done),
        .state_dbg (byte_state)
    );

    assign link.tx         = tx_line;
    assign link.busy       = busy_q;
    assign link.done       = done_q;
    assign link.byte_state = byte_state;

endmodule

// File: tb/tb_game_link_tx.sv
// Directed plus randomized bench for game_link_tx; expected line levels come from a bit-stream model of the message.
module tb_game_link_tx;
  import game_link_pkg::*;

  localparam int CPB = 4;
`ifdef GAME_LINK_TX_PARITY_EN
  localparam int BITS_PER_FRAME = 11;
`else
  localparam int BITS_PER_FRAME = 10;
`endif

  logic pclk = 1'b0;
  logic rst_n = 1'b0;

  game_link_tx_if link();

  game_link_tx #(.CLKS_PER_BIT(CPB)) dut (
    .pclk  (pclk),
    .rst_n (rst_n),
    .link  (link)
  );

  always #5 pclk = ~pclk;

  int n_asserts = 0;
  int n_fail = 0;
  logic [7:0] exp_q[$];
  logic bit_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Message model: byte list from the protocol rules, then one line level per bit time.
  task automatic build_expected(input bit is_score, input logic [15:0] sc);
    logic [7:0] b;
    exp_q.delete();
    bit_q.delete();
    if (is_score) begin
      exp_q.push_back(8'h5C);
      exp_q.push_back(sc[15:8]);
      exp_q.push_back(sc[7:0]);
      exp_q.push_back(8'h5C ^ sc[15:8] ^ sc[7:0]);
    end else begin
      exp_q.push_back(8'hA5);
    end
    foreach (exp_q[k]) begin
      b = exp_q[k];
      bit_q.push_back(1'b0);
      for (int i = 0; i < 8; i++) bit_q.push_back(b[i]);
`ifdef GAME_LINK_TX_PARITY_EN
      bit_q.push_back(^b);
`endif
      bit_q.push_back(1'b1);
    end
  endtask

  // Called at a negedge; returns at the negedge of the done cycle.
  task automatic run_msg(input bit rdy, input bit scr, input logic [15:0] sc, input int disturb_at);
    int total;
    build_expected(scr, sc);
    total = bit_q.size() * CPB;
    link.send_ready = rdy;
    link.send_score = scr;
    link.score = sc;
    @(negedge pclk);
    link.send_ready = 1'b0;
    link.send_score = 1'b0;
    for (int c = 0; c < total; c++) begin
      if (c == disturb_at) begin
        link.send_ready = 1'b1;
        link.send_score = 1'($urandom_range(0, 1));
        link.score = 16'($urandom);
      end else begin
        link.send_ready = 1'b0;
        link.send_score = 1'b0;
      end
      check("tx_bit", 32'(link.tx), 32'(bit_q[c / CPB]));
      check("busy_mid", 32'(link.busy), 32'd1);
      check("done_mid", 32'(link.done), 32'd0);
      @(negedge pclk);
    end
    link.send_ready = 1'b0;
    link.send_score = 1'b0;
    check("busy_end", 32'(link.busy), 32'd0);
    check("done_end", 32'(link.done), 32'd1);
    check("tx_end", 32'(link.tx), 32'd1);
  endtask

  task automatic idle_check();
    @(negedge pclk);
    check("idle_done", 32'(link.done), 32'd0);
    check("idle_busy", 32'(link.busy), 32'd0);
    check("idle_tx", 32'(link.tx), 32'd1);
  endtask

  initial begin
    logic [15:0] sc;
    link.send_ready = 1'b0;
    link.send_score = 1'b0;
    link.score = 16'h0000;

    repeat (3) @(negedge pclk);
    check("rst_tx", 32'(link.tx), 32'd1);
    check("rst_busy", 32'(link.busy), 32'd0);
    check("rst_done", 32'(link.done), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge pclk);
    check("post_rst_tx", 32'(link.tx), 32'd1);
    check("post_rst_busy", 32'(link.busy), 32'd0);

    // READY alone, then SCORE 0x1234, then both requests together.
    run_msg(1'b1, 1'b0, 16'h0000, -1);
    idle_check();
    run_msg(1'b0, 1'b1, 16'h1234, -1);
    idle_check();
    run_msg(1'b1, 1'b1, 16'hC0DE, -1);
    idle_check();

    // Request and score change while busy must not affect the message in flight.
    run_msg(1'b0, 1'b1, 16'h5AF0, 50);
    idle_check();
    run_msg(1'b1, 1'b0, 16'h0000, BITS_PER_FRAME * CPB - 1);
    idle_check();

    // Reset during the second SCORE byte.
    link.send_score = 1'b1;
    link.score = 16'hBEEF;
    @(negedge pclk);
    link.send_score = 1'b0;
    repeat (BITS_PER_FRAME * CPB + 6) @(negedge pclk);
    check("pre_rst_busy", 32'(link.busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_tx", 32'(link.tx), 32'd1);
    check("async_rst_busy", 32'(link.busy), 32'd0);
    check("async_rst_done", 32'(link.done), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge pclk);
      check("in_rst_done", 32'(link.done), 32'd0);
      check("in_rst_tx", 32'(link.tx), 32'd1);
    end
    rst_n = 1'b1;
    @(negedge pclk);
    check("after_rst_done", 32'(link.done), 32'd0);
    run_msg(1'b1, 1'b0, 16'h0000, -1);
    idle_check();

    // Random messages issued back to back, each accepted in the previous done cycle.
    for (int m = 0; m < 8; m++) begin
      sc = 16'($urandom);
      if ($urandom_range(0, 1) == 1)
        run_msg(1'($urandom_range(0, 1)), 1'b1, sc, int'($urandom_range(0, 4 * BITS_PER_FRAME * CPB + 20)));
      else
        run_msg(1'b1, 1'b0, sc, int'($urandom_range(0, BITS_PER_FRAME * CPB + 5)));
    end
    idle_check();

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
